pc_fetch_unit: RTL and testbench

Program-counter register and instruction-fetch sequencer for the 16-bit datapath. It holds the PC and issues one instruction-memory read at a time over a valid/ready request channel. It drives the 16-bit ADD unit with the operands PC and increment, and takes the ADD sum back as the sequential next PC. Fetched instructions go downstream to decode over a valid/ready channel. Branch and jump redirects arrive on a single redirect port.

---
 rtl/pc_fetch_unit.sv | 104 ++++++++++
 tb/tb_pc_fetch_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction fetch sequencer; sequential PC comes from the external ADD unit.
// REQ->WAIT->HOLD per instruction; req_valid holds until accepted, instr holds until decode takes it.
module pc_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'h0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  input  logic [15:0] add_sum,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [15:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [15:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr,
  output logic [15:0] instr_pc
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state, state_nxt, resume;
  logic [15:0] pc, pc_nxt;
  logic        discard, discard_nxt;
  logic        instr_valid_nxt;
  logic [15:0] instr_nxt, instr_pc_nxt;

  assign add_a          = pc;
  assign add_b          = PC_INC;
  assign imem_addr      = pc;
  assign imem_req_valid = (state == REQ);
  assign resume         = stall ? IDLE : REQ;

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    discard_nxt     = discard;
    instr_valid_nxt = instr_valid;
    instr_nxt       = instr;
    instr_pc_nxt    = instr_pc;
    case (state)
      IDLE: begin
        if (!stall) state_nxt = REQ;
      end
      REQ: begin
        // An accepted request racing a redirect is for the old PC; its response must be dropped.
        if (imem_req_ready) begin
          state_nxt = WAIT;
          if (redirect_valid) discard_nxt = 1'b1;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (discard || redirect_valid) begin
            discard_nxt = 1'b0;
            state_nxt   = resume;
          end else begin
            instr_nxt       = imem_rsp_data;
            instr_pc_nxt    = pc;
            instr_valid_nxt = 1'b1;
            pc_nxt          = add_sum;
            state_nxt       = HOLD;
          end
        end else if (redirect_valid) begin
          discard_nxt = 1'b1;
        end
      end
      HOLD: begin
        // A redirect without a handshake squashes the held instruction.
        if (instr_ready || redirect_valid) begin
          instr_valid_nxt = 1'b0;
          state_nxt       = resume;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (redirect_valid) pc_nxt = redirect_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      discard     <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= 16'h0000;
      instr_pc    <= 16'h0000;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      discard     <= discard_nxt;
      instr_valid <= instr_valid_nxt;
      instr       <= instr_nxt;
      instr_pc    <= instr_pc_nxt;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed scenarios plus a randomized phase, checked against a transaction-level fetch-order model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] add_a, add_b, add_sum;
  logic        imem_req_valid, imem_req_ready;
  logic [15:0] imem_addr;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        instr_valid, instr_ready;
  logic [15:0] instr, instr_pc;

  pc_fetch_unit #(.RESET_PC(16'h0000), .PC_INC(16'h0001)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  // External 16-bit ADD unit.
  assign add_sum = add_a + add_b;

  int          compared = 0;
  int          mismatched = 0;
  int          n_deliv = 0;
  logic [15:0] exp_pc;
  logic [15:0] last_pc;
  bit          pend;
  int          pend_cnt;
  logic [15:0] pend_addr;
  int          lat;
  bit          accepted;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h9C31;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One clock: sample/model at negedge, then the memory model drives its response after the edge.
  task automatic cyc();
    @(negedge clk);
    accepted = 0;
    chk("add_b", add_b, 16'h0001);
    chk("no_x", 16'($isunknown({imem_addr, imem_req_valid, instr_valid, instr, instr_pc})), 16'h0000);
    if (imem_req_valid === 1'b1) begin
      chk("req_addr", imem_addr, exp_pc);
      chk("add_a", add_a, exp_pc);
      if (imem_req_ready) begin
        pend = 1; pend_addr = imem_addr; pend_cnt = lat; accepted = 1;
      end
    end
    if (instr_valid === 1'b1 && instr_ready) begin
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr", instr, memf(exp_pc));
      last_pc = instr_pc;
      exp_pc  = exp_pc + 16'h0001;
      n_deliv++;
    end
    if (redirect_valid) exp_pc = redirect_pc;
    @(posedge clk); #1;
    imem_rsp_valid = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memf(pend_addr);
        pend = 0;
      end
    end
  endtask

  task automatic redir(input logic [15:0] t);
    redirect_valid = 1'b1; redirect_pc = t;
    cyc();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_deliver(input string tag, input int budget);
    int n0 = n_deliv;
    for (int i = 0; i < budget && n_deliv == n0; i++) cyc();
    chk(tag, 16'(n_deliv - n0), 16'd1);
  endtask

  task automatic wait_reqv(input string tag, input int budget);
    for (int i = 0; i < budget && imem_req_valid !== 1'b1; i++) cyc();
    chk(tag, 16'(imem_req_valid), 16'h0001);
  endtask

  task automatic wait_accept(input string tag, input int budget);
    accepted = 0;
    for (int i = 0; i < budget && !accepted; i++) cyc();
    chk(tag, 16'(accepted), 16'h0001);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_valid"}, 16'(imem_req_valid), 16'h0000);
    chk({tag, "_addr"}, imem_addr, 16'h0000);
    chk({tag, "_instr_valid"}, 16'(instr_valid), 16'h0000);
    chk({tag, "_instr"}, instr, 16'h0000);
    chk({tag, "_instr_pc"}, instr_pc, 16'h0000);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 16'h0000;
    instr_ready = 1'b0; exp_pc = 16'h0000; last_pc = 16'h0000;
    pend = 0; pend_cnt = 0; pend_addr = 16'h0000; lat = 1; accepted = 0;

    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    chk("rst_add_a", add_a, 16'h0000);
    chk("rst_add_b", add_b, 16'h0001);
    rst_n = 1'b1;

    // Sequential fetch 0000, 0001, 0002.
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_deliver("seq_deliver", 12);
      chk("seq_pc", last_pc, 16'(k));
    end

    // Wrap from FFFF to 0000.
    redir(16'hFFFF);
    wait_deliver("wrap_deliver0", 16);
    chk("wrap_pc0", last_pc, 16'hFFFF);
    wait_deliver("wrap_deliver1", 12);
    chk("wrap_pc1", last_pc, 16'h0000);

    // Redirect while waiting on a slow response.
    lat = 3;
    wait_accept("rdw_accept", 12);
    redir(16'h0040);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("rdw_no_stale", 16'(instr_valid), 16'h0000);
    end
    lat = 1;
    wait_deliver("rdw_deliver", 16);
    chk("rdw_pc", last_pc, 16'h0040);

    // Decode backpressure: held instruction stays stable, no new request.
    instr_ready = 1'b0;
    for (int i = 0; i < 12 && instr_valid !== 1'b1; i++) cyc();
    chk("hold_reach", 16'(instr_valid), 16'h0001);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("hold_valid", 16'(instr_valid), 16'h0001);
      chk("hold_pc", instr_pc, exp_pc);
      chk("hold_instr", instr, memf(exp_pc));
      chk("hold_no_req", 16'(imem_req_valid), 16'h0000);
    end
    instr_ready = 1'b1;
    cyc();
    wait_reqv("hold_next_req", 4);

    // Stall while a request waits for the memory.
    imem_req_ready = 1'b0;
    wait_reqv("stall_reqv", 8);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_req_held", 16'(imem_req_valid), 16'h0001);
    end
    imem_req_ready = 1'b1;
    wait_deliver("stall_deliver", 12);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("stall_idle", 16'(imem_req_valid), 16'h0000);
    end
    stall = 1'b0;
    wait_reqv("stall_resume", 4);
    chk("stall_resume_addr", imem_addr, exp_pc);

    // Asynchronous reset while waiting; a late response is ignored.
    lat = 3;
    wait_accept("rst_accept", 12);
    #2 rst_n = 1'b0;
    #1 chk_reset("arst");
    pend = 0; exp_pc = 16'h0000; imem_rsp_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; imem_req_ready = 1'b0; lat = 1;
    imem_rsp_valid = 1'b1; imem_rsp_data = 16'hDEAD;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("late_rsp_ignored", 16'(instr_valid), 16'h0000);
    end
    imem_req_ready = 1'b1;
    wait_deliver("restart_deliver", 12);
    chk("restart_pc", last_pc, 16'h0000);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      stall          = ($urandom_range(3) == 0);
      imem_req_ready = ($urandom_range(4) < 3);
      instr_ready    = ($urandom_range(4) < 3);
      lat            = 1 + $urandom_range(2);
      if ($urandom_range(9) == 0) redir(16'($urandom));
      else cyc();
    end
    stall = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1; lat = 1;
    wait_deliver("drain0", 24);
    wait_deliver("drain1", 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
